fsm3_seq_ctrl: RTL and testbench

FSM3_SEQ_CTRL -- requirements
Module: fsm3_seq_ctrl

---
 rtl/fsm3_seq_ctrl.sv | 119 +++++++++++
 tb/tb_fsm3_seq_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fsm3_seq_ctrl.sv
// One-hot A/B/C/D sequence detector for the serial pattern "101", with a
// saturating match counter and a threshold pulse. Define FSM3_ONEHOT_CHECK_EN
// to add the illegal-load checker that drives the sticky err output.
module fsm3_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             din,
  input  logic             din_valid,
  input  logic             ld_valid,
  input  logic [3:0]       ld_state,
  input  logic [CNT_W-1:0] thresh,
  input  logic             clr_cnt,
  output logic [3:0]       state,
  output logic             dout,
  output logic [CNT_W-1:0] match_cnt,
  output logic             thresh_hit,
  output logic             err
);

  typedef enum logic [3:0] {
    ST_A = 4'b0001,
    ST_B = 4'b0010,
    ST_C = 4'b0100,
    ST_D = 4'b1000
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit_q, hit_d;
  logic [3:0]       step_next;
  logic             enter_d;

  // Per-bit equations, so a non-one-hot state advances as the OR of its bits.
  always_comb begin
    step_next[0] = (state_q[0] | state_q[2]) & ~din;
    step_next[1] = (state_q[0] | state_q[1] | state_q[3]) & din;
    step_next[2] = (state_q[1] | state_q[3]) & ~din;
    step_next[3] = state_q[2] & din;
  end

`ifdef FSM3_ONEHOT_CHECK_EN
  logic err_q, err_d;
  logic ld_onehot;

  assign ld_onehot = (ld_state != 4'b0000) && ((ld_state & (ld_state - 4'b0001)) == 4'b0000);
`endif

  always_comb begin
    state_d = state_q;
    enter_d = 1'b0;
`ifdef FSM3_ONEHOT_CHECK_EN
    err_d   = err_q;
`endif
    if (ld_valid) begin
`ifdef FSM3_ONEHOT_CHECK_EN
      if (ld_onehot) begin
        state_d = ld_state;
      end else begin
        state_d = ST_A;
        err_d   = 1'b1;
      end
`else
      state_d = ld_state;
`endif
    end else if (din_valid) begin
      state_d = step_next;
      enter_d = step_next[3];
    end
  end

  // Clear beats increment; the pulse fires only on a real change onto thresh.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = CNT_ZERO;
    end else if (enter_d && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
    hit_d = (cnt_d != cnt_q) && (cnt_d == thresh) && (thresh != CNT_ZERO);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= ST_A;
      cnt_q   <= CNT_ZERO;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
    end
  end

`ifdef FSM3_ONEHOT_CHECK_EN
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign state      = state_q;
  assign dout       = (state_q == ST_D);
  assign match_cnt  = cnt_q;
  assign thresh_hit = hit_q;

endmodule

// File: tb/tb_fsm3_seq_ctrl.sv
// Directed bench for fsm3_seq_ctrl: a CNT_W=8 instance plus a CNT_W=2
// instance driven by the same stimulus for the saturation scenario.
module tb_fsm3_seq_ctrl;

  logic       clk = 1'b0;
  logic       areset;
  logic       din;
  logic       din_valid;
  logic       ld_valid;
  logic [3:0] ld_state;
  logic [7:0] thresh;
  logic [1:0] thresh2;
  logic       clr_cnt;

  logic [3:0] state, state2;
  logic       dout, dout2;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt2;
  logic       thresh_hit, thresh_hit2;
  logic       err, err2;

  int checkCnt = 0;
  int passCnt  = 0;

  fsm3_seq_ctrl #(.CNT_W(8)) dut (
    .clk(clk), .areset(areset), .din(din), .din_valid(din_valid),
    .ld_valid(ld_valid), .ld_state(ld_state), .thresh(thresh), .clr_cnt(clr_cnt),
    .state(state), .dout(dout), .match_cnt(match_cnt), .thresh_hit(thresh_hit), .err(err)
  );

  fsm3_seq_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .areset(areset), .din(din), .din_valid(din_valid),
    .ld_valid(ld_valid), .ld_state(ld_state), .thresh(thresh2), .clr_cnt(clr_cnt),
    .state(state2), .dout(dout2), .match_cnt(match_cnt2), .thresh_hit(thresh_hit2), .err(err2)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic bitIn);
    din       = bitIn;
    din_valid = 1'b1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic doReset();
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    #2;
    checkCnt++; if (state !== 4'b0001) $display("[TB] FAIL reset_state got=%b exp=0001", state); else passCnt++;
    checkCnt++; if (dout !== 1'b0) $display("[TB] FAIL reset_dout got=%b exp=0", dout); else passCnt++;
    checkCnt++; if (match_cnt !== 8'd0) $display("[TB] FAIL reset_cnt got=%0d exp=0", match_cnt); else passCnt++;
    checkCnt++; if (thresh_hit !== 1'b0 || err !== 1'b0) $display("[TB] FAIL reset_hit_err got=%b%b exp=00", thresh_hit, err); else passCnt++;
    @(negedge clk);
    areset = 1'b0;
    #1;
  endtask

  task automatic test_match();
    doReset();
    thresh = 8'd0;
    applyStimulus(1'b1);
    checkCnt++; if (state !== 4'b0010) $display("[TB] FAIL match_s1 got=%b exp=0010", state); else passCnt++;
    applyStimulus(1'b0);
    checkCnt++; if (state !== 4'b0100) $display("[TB] FAIL match_s2 got=%b exp=0100", state); else passCnt++;
    applyStimulus(1'b1);
    checkCnt++; if (state !== 4'b1000 || dout !== 1'b1) $display("[TB] FAIL match_s3 got=%b/%b exp=1000/1", state, dout); else passCnt++;
    checkCnt++; if (match_cnt !== 8'd1) $display("[TB] FAIL match_cnt got=%0d exp=1", match_cnt); else passCnt++;
    checkCnt++; if (thresh_hit !== 1'b0) $display("[TB] FAIL match_thresh0 got=%b exp=0", thresh_hit); else passCnt++;
    // Idle cycle with no valid must hold state
    @(posedge clk); #1;
    checkCnt++; if (state !== 4'b1000 || match_cnt !== 8'd1) $display("[TB] FAIL match_hold got=%b/%0d exp=1000/1", state, match_cnt); else passCnt++;
  endtask

  task automatic test_thresh();
    doReset();
    thresh = 8'd2;
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    checkCnt++; if (match_cnt !== 8'd1 || thresh_hit !== 1'b0) $display("[TB] FAIL thr_first got=%0d/%b exp=1/0", match_cnt, thresh_hit); else passCnt++;
    applyStimulus(1'b0);
    checkCnt++; if (thresh_hit !== 1'b0) $display("[TB] FAIL thr_mid got=%b exp=0", thresh_hit); else passCnt++;
    applyStimulus(1'b1);
    checkCnt++; if (match_cnt !== 8'd2 || thresh_hit !== 1'b1) $display("[TB] FAIL thr_hit got=%0d/%b exp=2/1", match_cnt, thresh_hit); else passCnt++;
    applyStimulus(1'b0);
    checkCnt++; if (match_cnt !== 8'd2 || thresh_hit !== 1'b0) $display("[TB] FAIL thr_after got=%0d/%b exp=2/0", match_cnt, thresh_hit); else passCnt++;
    thresh = 8'd0;
  endtask

  task automatic test_saturate();
    doReset();
    thresh2 = 2'd0;
    applyStimulus(1'b1);
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0);
      applyStimulus(1'b1);
    end
    checkCnt++; if (match_cnt2 !== 2'd3) $display("[TB] FAIL sat_cnt2 got=%0d exp=3", match_cnt2); else passCnt++;
    checkCnt++; if (match_cnt !== 8'd7) $display("[TB] FAIL sat_cnt8 got=%0d exp=7", match_cnt); else passCnt++;
    checkCnt++; if (state2 !== 4'b1000) $display("[TB] FAIL sat_state got=%b exp=1000", state2); else passCnt++;
  endtask

  task automatic test_clear();
    doReset();
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    clr_cnt = 1'b1;
    applyStimulus(1'b1);
    clr_cnt = 1'b0;
    checkCnt++; if (match_cnt !== 8'd0) $display("[TB] FAIL clr_cnt got=%0d exp=0", match_cnt); else passCnt++;
    checkCnt++; if (state !== 4'b1000) $display("[TB] FAIL clr_state got=%b exp=1000", state); else passCnt++;
  endtask

  task automatic test_load();
    doReset();
    // A load into D sets dout but is not a match
    ld_valid = 1'b1; ld_state = 4'b1000;
    @(posedge clk); #1;
    ld_valid = 1'b0;
    checkCnt++; if (state !== 4'b1000 || dout !== 1'b1) $display("[TB] FAIL ldD_state got=%b/%b exp=1000/1", state, dout); else passCnt++;
    checkCnt++; if (match_cnt !== 8'd0) $display("[TB] FAIL ldD_cnt got=%0d exp=0", match_cnt); else passCnt++;
    // Illegal load with a simultaneous step: load wins
    ld_valid = 1'b1; ld_state = 4'b0110;
    applyStimulus(1'b1);
    ld_valid = 1'b0;
`ifdef FSM3_ONEHOT_CHECK_EN
    checkCnt++; if (state !== 4'b0001 || err !== 1'b1) $display("[TB] FAIL ldBad got=%b/%b exp=0001/1", state, err); else passCnt++;
    applyStimulus(1'b1);
    checkCnt++; if (err !== 1'b1) $display("[TB] FAIL err_sticky got=%b exp=1", err); else passCnt++;
`else
    checkCnt++; if (state !== 4'b0110 || err !== 1'b0) $display("[TB] FAIL ldBad got=%b/%b exp=0110/0", state, err); else passCnt++;
    applyStimulus(1'b1);
    checkCnt++; if (state !== 4'b1010) $display("[TB] FAIL ldBad_step got=%b exp=1010", state); else passCnt++;
`endif
  endtask

  task automatic test_async_reset();
    doReset();
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    applyStimulus(1'b0);
    checkCnt++; if (state !== 4'b0100 || match_cnt !== 8'd1) $display("[TB] FAIL ar_pre got=%b/%0d exp=0100/1", state, match_cnt); else passCnt++;
    #2;
    areset = 1'b1;
    #1;
    checkCnt++; if (state !== 4'b0001 || match_cnt !== 8'd0) $display("[TB] FAIL ar_now got=%b/%0d exp=0001/0", state, match_cnt); else passCnt++;
    checkCnt++; if (err !== 1'b0) $display("[TB] FAIL ar_err got=%b exp=0", err); else passCnt++;
    @(negedge clk);
    areset = 1'b0;
    #1;
    applyStimulus(1'b1);
    checkCnt++; if (state !== 4'b0010 || match_cnt !== 8'd0) $display("[TB] FAIL ar_after got=%b/%0d exp=0010/0", state, match_cnt); else passCnt++;
  endtask

  initial begin
    areset    = 1'b0;
    din       = 1'b0;
    din_valid = 1'b0;
    ld_valid  = 1'b0;
    ld_state  = 4'b0001;
    thresh    = 8'd0;
    thresh2   = 2'd0;
    clr_cnt   = 1'b0;
    #1;
    test_reset();
    test_match();
    test_thresh();
    test_saturate();
    test_clear();
    test_load();
    test_async_reset();
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
